// File: rtl/lstm_seq_driver_pkg.sv
// Shared definitions for the LSTM sequence driver: Q-format widths, helpers, FSM encoding.
package lstm_seq_driver_pkg;

    localparam int unsigned QN_DEF = 6;
    localparam int unsigned QM_DEF = 11;

    // Element width of a signed QN.QM fixed-point value (sign + integer + fraction).
    function automatic int unsigned bitWidth(input int unsigned qn, input int unsigned qm);
        return qn + qm + 1;
    endfunction

    localparam int unsigned BITWIDTH_DEF = bitWidth(QN_DEF, QM_DEF);

    // 1.0 in the default Q-format.
    localparam logic [BITWIDTH_DEF-1:0] ONE = BITWIDTH_DEF'(1) << QM_DEF;

    // Integer ceil(log2(value)); 0 for value <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Counter width that is never zero, even for a count range of one.
    function automatic int unsigned idxWidth(input int unsigned n);
        int unsigned w = clog2(n);
        return (w == 0) ? 1 : w;
    endfunction

    typedef enum logic [2:0] {
        SeqRst  = 3'd0,
        WaitIn  = 3'd1,
        Issue   = 3'd2,
        WaitNet = 3'd3,
        Gap1    = 3'd4,
        Perc    = 3'd5,
        Gap2    = 3'd6,
        Out     = 3'd7
    } seqState_t;

endpackage

// File: rtl/lstm_seq_driver_edge_wait_timer.sv
// Rising-edge detector on a done level plus a saturating wait-timeout counter.
module lstm_seq_driver_edge_wait_timer
    import lstm_seq_driver_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 4095
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,    // restart the wait (pulse on the cycle before the wait state)
    input  logic active,   // count while waiting
    input  logic level,    // done level from the downstream block
    output logic rose,
    output logic expired
);

    localparam int unsigned CW = idxWidth(TIMEOUT_CYC + 1);

    logic          levelQ;
    logic [CW-1:0] count;

    // Previous level for edge detection and the timeout counter, which stops at the limit.
    always_ff @(posedge clock) begin
        if (reset) begin
            levelQ <= 1'b0;
            count  <= '0;
        end else begin
            levelQ <= level;
            if (clear) begin
                count <= '0;
            end else if (active && !expired) begin
                count <= count + 1'b1;
            end
        end
    end

    // A level already high when the wait begins was sampled into levelQ, so it never counts.
    assign rose    = level & ~levelQ;
    assign expired = (count == CW'(TIMEOUT_CYC));

endmodule

// File: rtl/lstm_seq_driver.sv
// Sequences one input vector at a time through the LSTM layer and the output perceptron.
module lstm_seq_driver
    import lstm_seq_driver_pkg::*;
#(
    parameter int unsigned INPUT_SZ    = 2,
    parameter int unsigned QN          = 6,
    parameter int unsigned QM          = 11,
    parameter int unsigned SEQ_LEN     = 8,
    parameter int unsigned SEQ_RST_CYC = 2,
    parameter int unsigned TIMEOUT_CYC = 4095,
    localparam int unsigned BITWIDTH   = bitWidth(QN, QM),
    localparam int unsigned IDX_W      = idxWidth(SEQ_LEN)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [INPUT_SZ*BITWIDTH-1:0] s_data,
    output logic                         net_reset,
    output logic [INPUT_SZ*BITWIDTH-1:0] net_inputVec,
    output logic                         net_newSample,
    input  logic                         net_dataReady,
    output logic                         perc_reset,
    input  logic                         perc_dataReady,
    input  logic [BITWIDTH-1:0]          perc_out,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [BITWIDTH-1:0]          m_data,
    output logic                         m_last,
    output logic [IDX_W-1:0]             sample_idx,
    output logic                         error
);

    localparam int unsigned RC_W = idxWidth(SEQ_RST_CYC);

    seqState_t                     state;
    logic [RC_W-1:0]               rstCnt;
    logic                          sReady;
    logic                          newSample;
    logic                          mValid;
    logic [BITWIDTH-1:0]           mData;
    logic                          mLast;
    logic [IDX_W-1:0]              sampleIdx;
    logic                          errorQ;
    logic [INPUT_SZ*BITWIDTH-1:0]  inputVec;
    logic                          netRst;
    logic                          percEn;

    logic netRose, netExpired;
    logic percRose, percExpired;

    lstm_seq_driver_edge_wait_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) netTimer (
        .clock  (clock),
        .reset  (reset),
        .clear  (state == Issue),
        .active (state == WaitNet),
        .level  (net_dataReady),
        .rose   (netRose),
        .expired(netExpired)
    );

    lstm_seq_driver_edge_wait_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) percTimer (
        .clock  (clock),
        .reset  (reset),
        .clear  (state == Gap1),
        .active (state == Perc),
        .level  (perc_dataReady),
        .rose   (percRose),
        .expired(percExpired)
    );

    // Sample sequencing FSM; every output flop is updated together with its state transition.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= SeqRst;
            rstCnt    <= '0;
            sReady    <= 1'b0;
            newSample <= 1'b0;
            mValid    <= 1'b0;
            mData     <= '0;
            mLast     <= 1'b0;
            sampleIdx <= '0;
            errorQ    <= 1'b0;
            inputVec  <= '0;
            netRst    <= 1'b1;
            percEn    <= 1'b0;
        end else begin
            unique case (state)
                SeqRst: begin
                    sampleIdx <= '0;
                    if (rstCnt == RC_W'(SEQ_RST_CYC - 1)) begin
                        state  <= WaitIn;
                        netRst <= 1'b0;
                        sReady <= 1'b1;
                    end else begin
                        rstCnt <= rstCnt + 1'b1;
                    end
                end
                WaitIn: begin
                    if (s_valid) begin
                        inputVec  <= s_data;
                        sReady    <= 1'b0;
                        newSample <= 1'b1;
                        state     <= Issue;
                    end
                end
                Issue: begin
                    newSample <= 1'b0;
                    state     <= WaitNet;
                end
                WaitNet: begin
                    if (netRose) begin
                        state <= Gap1;
                    end else if (netExpired) begin
                        // Drop the sample and restart the sequence from zero state.
                        errorQ <= 1'b1;
                        state  <= SeqRst;
                        rstCnt <= '0;
                        netRst <= 1'b1;
                    end
                end
                Gap1: begin
                    percEn <= 1'b1;
                    state  <= Perc;
                end
                Perc: begin
                    if (percRose) begin
                        state <= Gap2;
                    end else if (percExpired) begin
                        errorQ <= 1'b1;
                        percEn <= 1'b0;
                        state  <= SeqRst;
                        rstCnt <= '0;
                        netRst <= 1'b1;
                    end
                end
                Gap2: begin
                    mData  <= perc_out;
                    mLast  <= (sampleIdx == IDX_W'(SEQ_LEN - 1));
                    mValid <= 1'b1;
                    percEn <= 1'b0;
                    state  <= Out;
                end
                Out: begin
                    if (m_ready) begin
                        mValid <= 1'b0;
                        if (mLast) begin
                            state  <= SeqRst;
                            rstCnt <= '0;
                            netRst <= 1'b1;
                        end else begin
                            sampleIdx <= sampleIdx + 1'b1;
                            sReady    <= 1'b1;
                            state     <= WaitIn;
                        end
                    end
                end
                default: begin
                    state  <= SeqRst;
                    rstCnt <= '0;
                    netRst <= 1'b1;
                end
            endcase
        end
    end

    // Both resets follow the system reset immediately, not a cycle late.
    assign net_reset     = reset | netRst;
    assign perc_reset    = reset | ~percEn;
    assign s_ready       = sReady;
    assign net_newSample = newSample;
    assign net_inputVec  = inputVec;
    assign m_valid       = mValid;
    assign m_data        = mData;
    assign m_last        = mLast;
    assign sample_idx    = sampleIdx;
    assign error         = errorQ;

endmodule

// File: tb/tb_lstm_seq_driver.sv
// Bench for lstm_seq_driver: stub layer/perceptron, result scoreboard and directed scenarios.
module tb_lstm_seq_driver;

    localparam int SEQ = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sValid = 1'b0;
    logic [35:0] sData = '0;
    logic        netDr = 1'b0;
    logic        percDr = 1'b0;
    logic [17:0] percOut = '0;
    logic        mReady = 1'b1;

    logic        sReady, netReset, newSample, percReset, mValid, mLast, error;
    logic [35:0] netVec;
    logic [17:0] mData;
    logic [2:0]  sampleIdx;

    always #5 clock = ~clock;

    lstm_seq_driver dut (
        .clock         (clock),
        .reset         (reset),
        .s_valid       (sValid),
        .s_ready       (sReady),
        .s_data        (sData),
        .net_reset     (netReset),
        .net_inputVec  (netVec),
        .net_newSample (newSample),
        .net_dataReady (netDr),
        .perc_reset    (percReset),
        .perc_dataReady(percDr),
        .perc_out      (percOut),
        .m_valid       (mValid),
        .m_ready       (mReady),
        .m_data        (mData),
        .m_last        (mLast),
        .sample_idx    (sampleIdx),
        .error         (error)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    int cyc = 0;
    always @(posedge clock) cyc++;

    // Stub environment: layer done level after netLat cycles, perceptron after percLat cycles.
    int netLat = 10;
    int percLat = 5;
    int netCnt = 0;
    bit netBusy = 0;
    int pCnt = 0;
    int pIdx = 0;
    logic [17:0] pTab [8] = '{18'h3FC00, 18'h00800, 18'h3F800, 18'h01000,
                              18'h00001, 18'h3FFFF, 18'h12345, 18'h2ABCD};

    typedef struct {
        logic [17:0] d;
        bit          last;
        int          idx;
    } exp_t;
    exp_t expQ[$];
    int   idxM = 0;

    always begin
        @(posedge clock);
        #1;
        if (netReset) begin
            netDr = 1'b0;
            netBusy = 0;
        end else if (newSample) begin
            netDr = 1'b0;
            netBusy = 1;
            netCnt = 0;
        end else if (netBusy) begin
            netCnt++;
            if (netLat >= 0 && netCnt == netLat) begin
                netDr = 1'b1;
                netBusy = 0;
            end
        end
        if (percReset) begin
            percDr = 1'b0;
            pCnt = 0;
        end else begin
            pCnt++;
            if (pCnt == percLat) begin
                percDr = 1'b1;
                percOut = pTab[pIdx % 8];
                expQ.push_back('{pTab[pIdx % 8], (idxM == SEQ - 1), idxM});
                pIdx++;
            end
        end
    end

    // Scoreboard: every perceptron result must come out once, in order, tagged with its position.
    logic prevAccept = 1'b0;
    logic errPrev = 1'b0;
    int   nsCount = 0;
    int   mvCount = 0;
    always @(negedge clock) begin
        if (reset) begin
            expQ.delete();
            idxM = 0;
            prevAccept = 1'b0;
            errPrev = 1'b0;
        end else begin
            if (newSample) nsCount++;
            if (mValid) mvCount++;
            check("newSample_follows_accept", newSample, prevAccept);
            check("s_ready_while_m_valid", sReady & mValid, 0);
            if (error && !errPrev) idxM = 0;
            errPrev = error;
            if (mValid) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL m_valid_unexpected: got m_valid=1 expected no pending result");
                end else begin
                    check("sb_m_data", mData, expQ[0].d);
                    check("sb_m_last", mLast, expQ[0].last);
                    check("sb_sample_idx", sampleIdx, expQ[0].idx);
                end
            end
            prevAccept = sValid & sReady;
            if (mValid && mReady && expQ.size() != 0) begin
                idxM = expQ[0].last ? 0 : idxM + 1;
                void'(expQ.pop_front());
            end
        end
    end

    task automatic sendVec(input logic [35:0] d, output int acc);
        int n = 0;
        @(posedge clock);
        #1;
        sValid = 1'b1;
        sData = d;
        do begin
            @(negedge clock);
            n++;
        end while (!sReady && n < 300);
        acc = cyc;
        if (n >= 300) check("send_timeout", 0, 1);
        @(posedge clock);
        #1;
        sValid = 1'b0;
    endtask

    task automatic waitResult(output logic [17:0] d, output bit l, output int i, output int c);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!mValid && n < 300);
        if (n >= 300) check("result_timeout", 0, 1);
        d = mData;
        l = mLast;
        i = int'(sampleIdx);
        c = cyc;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic [17:0] d;
        bit          l;
        int          i, acc, c, n, ns0, mv0, errCyc;

        // Power-up reset
        repeat (3) begin
            @(negedge clock);
            check("rst_net_reset", netReset, 1);
            check("rst_perc_reset", percReset, 1);
            check("rst_s_ready", sReady, 0);
            check("rst_m_valid", mValid, 0);
        end
        check("rst_error", error, 0);
        check("rst_sample_idx", sampleIdx, 0);
        check("rst_m_data", mData, 0);
        check("rst_net_inputVec", netVec, 0);
        check("rst_newSample", newSample, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rel1_net_reset", netReset, 1);
        check("rel1_s_ready", sReady, 0);
        @(negedge clock);
        check("rel2_net_reset", netReset, 1);
        check("rel2_s_ready", sReady, 0);
        @(negedge clock);
        check("rel3_net_reset", netReset, 0);
        check("rel3_s_ready", sReady, 1);

        // Single sample: layer 10 cycles, perceptron 5 cycles
        ns0 = nsCount;
        sendVec({18'h00800, 18'h00400}, acc);
        waitResult(d, l, i, c);
        check("single_net_inputVec", netVec, {18'h00800, 18'h00400});
        check("single_m_data", d, 18'h3FC00);
        check("single_m_last", l, 0);
        check("single_idx", i, 0);
        check("single_latency", c - acc, 19);
        check("single_newSample_count", nsCount - ns0, 1);

        // Rest of the sequence with short latencies, m_ready always high
        @(posedge clock);
        #1;
        netLat = 3;
        percLat = 2;
        for (int k = 1; k < 8; k++) begin
            sendVec({18'(k), 18'(k * 3)}, acc);
            waitResult(d, l, i, c);
            check("seq_m_data", d, pTab[k]);
            check("seq_m_last", l, (k == 7));
            check("seq_idx", i, k);
        end
        @(negedge clock);
        check("seqend_net_reset1", netReset, 1);
        check("seqend_s_ready1", sReady, 0);
        check("seqend_m_valid", mValid, 0);
        @(negedge clock);
        check("seqend_net_reset2", netReset, 1);
        @(negedge clock);
        check("seqend_net_reset3", netReset, 0);
        check("seqend_s_ready3", sReady, 1);
        check("seqend_idx_wrap", sampleIdx, 0);
        sendVec(36'h0_0001_0002, acc);
        waitResult(d, l, i, c);
        check("s9_idx", i, 0);
        check("s9_m_data", d, pTab[0]);
        check("s9_m_last", l, 0);

        // Backpressure with a competing input held pending
        @(posedge clock);
        #1;
        mReady = 1'b0;
        sendVec(36'h1_2345_6789, acc);
        waitResult(d, l, i, c);
        check("bp_idx", i, 1);
        check("bp_m_data", d, pTab[1]);
        @(posedge clock);
        #1;
        sValid = 1'b1;
        sData = 36'hA_BCDE_0123;
        ns0 = nsCount;
        repeat (20) begin
            @(negedge clock);
            check("bp_m_valid_held", mValid, 1);
            check("bp_m_data_held", mData, pTab[1]);
            check("bp_s_ready_low", sReady, 0);
        end
        check("bp_no_newSample", nsCount - ns0, 0);
        @(posedge clock);
        #1;
        mReady = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!sReady && n < 50);
        check("bp_pending_accepted", sReady, 1);
        @(posedge clock);
        #1;
        sValid = 1'b0;
        waitResult(d, l, i, c);
        check("bp_pending_vec", netVec, 36'hA_BCDE_0123);
        check("bp_pending_idx", i, 2);
        check("bp_pending_data", d, pTab[2]);

        // Stuck layer: timeout, sticky error, no result
        @(posedge clock);
        #1;
        netLat = -1;
        mv0 = mvCount;
        sendVec(36'h0_0000_0055, acc);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!error && n < 5000);
        errCyc = cyc;
        check("stuck_error_set", error, 1);
        check("stuck_window", ((errCyc - (acc + 1)) >= 4095) && ((errCyc - (acc + 1)) <= 4100), 1);
        check("stuck_in_seq_rst", netReset, 1);
        check("stuck_no_m_valid", mvCount - mv0, 0);
        repeat (30) @(negedge clock);
        check("stuck_error_sticky", error, 1);
        check("stuck_idx_zero", sampleIdx, 0);
        check("stuck_s_ready", sReady, 1);

        // Reset during PERC
        @(posedge clock);
        #1;
        netLat = 3;
        percLat = 10;
        sendVec(36'h0_0000_0077, acc);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (percReset && n < 100);
        check("perc_enabled", percReset, 0);
        repeat (2) @(negedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        check("midrst_perc_reset", percReset, 1);
        check("midrst_net_reset", netReset, 1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        mv0 = mvCount;
        @(negedge clock);
        check("midrst_m_valid", mValid, 0);
        check("midrst_error_cleared", error, 0);
        check("midrst_idx", sampleIdx, 0);
        check("midrst_net_reset_after", netReset, 1);
        repeat (40) @(negedge clock);
        check("midrst_no_result", mvCount - mv0, 0);
        check("midrst_s_ready", sReady, 1);
        @(posedge clock);
        #1;
        netLat = 10;
        percLat = 5;
        sendVec(36'h0_0400_0800, acc);
        waitResult(d, l, i, c);
        check("fresh_idx", i, 0);
        check("fresh_m_data", d, pTab[3]);
        check("fresh_latency", c - acc, 19);
        repeat (3) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
